palette_decoder: RTL

Unpacks sprite/tile ROM words of packed 4-bit palette indices into a stream of 24-bit `rgb_t` pixels (`{r,g,b}`), one pixel per clock, for the renderer's sprite and tile layers. It is the read side of the game colour palette: objects are stored as indices, and this block turns them back into the palette colours the compositor and VGA stage consume. It has valid/ready handshakes on both sides and flags the magenta transparency key for the compositor.

---
 rtl/palette_decoder_if.sv | 26 ++
 rtl/palette_decoder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/palette_decoder_if.sv
// Stream bundle for palette_decoder: packed-index words in,
// 24-bit {r,g,b} pixels out, plus the busy status flag.
interface palette_decoder_if #(
  parameter int PIX_PER_WORD = 8
);
  logic                      s_valid;
  logic                      s_ready;
  logic [4*PIX_PER_WORD-1:0] s_data;
  logic                      s_last;
  logic                      m_valid;
  logic                      m_ready;
  logic [23:0]               m_rgb;
  logic                      m_transparent;
  logic                      m_last;
  logic                      busy;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_rgb, m_transparent, m_last, busy
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_rgb, m_transparent, m_last, busy
  );
endinterface

// File: rtl/palette_decoder.sv
// Unpacks 4-bit palette indices into {r,g,b} pixels, one per clock.
// Define PALETTE_WRITE_EN for a writable palette with pal_* ports.
module palette_decoder #(
  parameter int PIX_PER_WORD = 8
) (
  input  logic               clk,
  input  logic               reset,
`ifdef PALETTE_WRITE_EN
  input  logic               pal_we,
  input  logic [3:0]         pal_addr,
  input  logic [23:0]        pal_data,
`endif
  palette_decoder_if.slave   bus
);

  localparam int W     = 4 * PIX_PER_WORD;
  localparam int CNT_W = $clog2(PIX_PER_WORD);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PIX_PER_WORD - 1);
  localparam logic [23:0] KEY = 24'hFF00FF;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic rgb_t default_color(input logic [3:0] i);
    case (i)
      4'd0:    return 24'hFF00FF;
      4'd1:    return 24'h87CEEB;
      4'd2:    return 24'h5DADE2;
      4'd3:    return 24'h7FC83F;
      4'd4:    return 24'h55A02F;
      4'd5:    return 24'h6B4A2F;
      4'd6:    return 24'h8B653F;
      4'd7:    return 24'hA07A50;
      4'd8:    return 24'h707070;
      4'd9:    return 24'h202020;
      4'd10:   return 24'h505050;
      4'd11:   return 24'hC0C0C0;
      4'd12:   return 24'hFF0000;
      4'd13:   return 24'h1E90FF;
      4'd14:   return 24'hFFCC00;
      default: return 24'hFFFFFF;
    endcase
  endfunction

  logic [W-1:0]     buf_data_q, buf_data_d;
  logic             buf_last_q, buf_last_d;
  logic             buf_valid_q, buf_valid_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic             m_valid_q, m_valid_d;
  rgb_t             m_rgb_q, m_rgb_d;
  logic             m_trans_q, m_trans_d;
  logic             m_last_q, m_last_d;

  logic             last_pix;
  logic             advance;
  logic             s_ready;
  logic [W-1:0]     shifted;
  logic [3:0]       idx;
  rgb_t             color;

`ifdef PALETTE_WRITE_EN
  rgb_t pal_q [16];
  rgb_t pal_d [16];

  // Palette write port; reset reloads defaults and overrides writes
  always_comb begin
    for (int i = 0; i < 16; i++) pal_d[i] = pal_q[i];
    if (pal_we) pal_d[pal_addr] = pal_data;
  end

  // Palette register file
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) pal_q[i] <= default_color(4'(i));
    end else begin
      for (int i = 0; i < 16; i++) pal_q[i] <= pal_d[i];
    end
  end
`endif

  // Current index selection and colour lookup
  always_comb begin
    shifted = buf_data_q >> {pix_cnt_q, 2'b00};
    idx     = shifted[3:0];
`ifdef PALETTE_WRITE_EN
    color   = pal_q[idx];
`else
    color   = default_color(idx);
`endif
  end

  assign last_pix = (pix_cnt_q == CNT_MAX);
  assign advance  = buf_valid_q && (!m_valid_q || bus.m_ready);
  assign s_ready  = !reset && (!buf_valid_q || (advance && last_pix));

  // Next state: word buffer, pixel counter and output stage
  always_comb begin
    buf_data_d  = buf_data_q;
    buf_last_d  = buf_last_q;
    buf_valid_d = buf_valid_q;
    pix_cnt_d   = pix_cnt_q;
    m_valid_d   = m_valid_q;
    m_rgb_d     = m_rgb_q;
    m_trans_d   = m_trans_q;
    m_last_d    = m_last_q;
    if (advance) begin
      m_valid_d = 1'b1;
      m_rgb_d   = color;
      m_trans_d = (color == KEY);
      m_last_d  = buf_last_q && last_pix;
      if (last_pix) begin
        pix_cnt_d   = '0;
        buf_valid_d = 1'b0;
      end else begin
        pix_cnt_d = pix_cnt_q + CNT_W'(1);
      end
    end else if (m_valid_q && bus.m_ready) begin
      m_valid_d = 1'b0;
    end
    if (bus.s_valid && s_ready) begin
      buf_data_d  = bus.s_data;
      buf_last_d  = bus.s_last;
      buf_valid_d = 1'b1;
    end
  end

  // Pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_data_q  <= '0;
      buf_last_q  <= 1'b0;
      buf_valid_q <= 1'b0;
      pix_cnt_q   <= '0;
      m_valid_q   <= 1'b0;
      m_rgb_q     <= '0;
      m_trans_q   <= 1'b0;
      m_last_q    <= 1'b0;
    end else begin
      buf_data_q  <= buf_data_d;
      buf_last_q  <= buf_last_d;
      buf_valid_q <= buf_valid_d;
      pix_cnt_q   <= pix_cnt_d;
      m_valid_q   <= m_valid_d;
      m_rgb_q     <= m_rgb_d;
      m_trans_q   <= m_trans_d;
      m_last_q    <= m_last_d;
    end
  end

  assign bus.s_ready       = s_ready;
  assign bus.m_valid       = m_valid_q;
  assign bus.m_rgb         = m_rgb_q;
  assign bus.m_transparent = m_trans_q;
  assign bus.m_last        = m_last_q;
  assign bus.busy          = buf_valid_q || m_valid_q;

endmodule
